// File: rtl/hash_display_pkg.sv
// Shared types and constants for the student-ID/time hash display unit.
package hash_display_pkg;

    typedef enum logic [1:0] {
        OFF_REL = 2'd0,
        ON_PRS  = 2'd1,
        ON_REL  = 2'd2,
        OFF_PRS = 2'd3
    } btn_state_t;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam int         HASH_W     = 16;
    localparam int         NUM_DIGITS = 5;

endpackage

// File: rtl/hash_display_unit_bcd.sv
// Combinational 16-bit binary to 5-digit BCD converter (shift-and-add-3).
module bin16_to_bcd5
    import hash_display_pkg::*;
(
    input  logic [HASH_W-1:0]         bin_i,
    output logic [NUM_DIGITS*4-1:0]   bcd_o
);

    logic [NUM_DIGITS*4+HASH_W-1:0] sh;

    always_comb begin
        sh = {{(NUM_DIGITS*4){1'b0}}, bin_i};
        for (int i = 0; i < HASH_W; i++) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (sh[HASH_W+4*d +: 4] > 4'd4) begin
                    sh[HASH_W+4*d +: 4] = sh[HASH_W+4*d +: 4] + 4'd3;
                end
            end
            sh = sh << 1;
        end
    end

    assign bcd_o = sh[NUM_DIGITS*4+HASH_W-1 -: NUM_DIGITS*4];

endmodule

// File: rtl/hash_display_unit.sv
// Rolling student-ID/time hash with BCD display gated by a push-button toggle.
// Define HASH_DISP_REG_OUT_EN to register the five digit outputs.
module hash_display_unit
    import hash_display_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HASH_ROT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button_in,
    input  logic              hash_tick,
    input  logic [HASH_W-1:0] cur_time,
    input  logic [HASH_W-1:0] student_id,
    output logic              stateful_button,
    output logic [HASH_W-1:0] cur_hash,
    output logic [3:0]        d5_out,
    output logic [3:0]        d4_out,
    output logic [3:0]        d3_out,
    output logic [3:0]        d2_out,
    output logic [3:0]        d1_out,
    output btn_state_t        fsm_state_o
);

    localparam int ROT = HASH_ROT % HASH_W;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    btn_state_t             state_q;
    logic                   button_q;
    logic [HASH_W-1:0]      hash_q, hash_d, tmp;
    logic [2*HASH_W-1:0]    dbl;
    logic [NUM_DIGITS*4-1:0] bcd, digits_d, digits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], button_in};
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    // Output bit is updated alongside the state so it is a registered Moore output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= OFF_REL;
            button_q <= 1'b0;
        end else begin
            case (state_q)
                OFF_REL: if (btn_s)  begin state_q <= ON_PRS;  button_q <= 1'b1; end
                ON_PRS:  if (!btn_s) begin state_q <= ON_REL;  button_q <= 1'b1; end
                ON_REL:  if (btn_s)  begin state_q <= OFF_PRS; button_q <= 1'b0; end
                OFF_PRS: if (!btn_s) begin state_q <= OFF_REL; button_q <= 1'b0; end
                default: begin state_q <= OFF_REL; button_q <= 1'b0; end
            endcase
        end
    end

    always_comb begin
        tmp    = (hash_q ^ student_id) + cur_time;
        dbl    = {tmp, tmp} << ROT;
        hash_d = hash_q;
        if (hash_tick) hash_d = dbl[2*HASH_W-1 -: HASH_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hash_q <= '0;
        else     hash_q <= hash_d;
    end

    bin16_to_bcd5 u_bcd (
        .bin_i (hash_q),
        .bcd_o (bcd)
    );

    assign digits_d = button_q ? bcd : {NUM_DIGITS{BCD_BLANK}};

`ifdef HASH_DISP_REG_OUT_EN
    logic [NUM_DIGITS*4-1:0] digits_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) digits_q <= {NUM_DIGITS{BCD_BLANK}};
        else     digits_q <= digits_d;
    end

    assign digits = digits_q;
`else
    assign digits = digits_d;
`endif

    assign stateful_button = button_q;
    assign cur_hash        = hash_q;
    assign fsm_state_o     = state_q;
    assign d5_out          = digits[19:16];
    assign d4_out          = digits[15:12];
    assign d3_out          = digits[11:8];
    assign d2_out          = digits[7:4];
    assign d1_out          = digits[3:0];

endmodule

// File: tb/tb_hash_display_unit.sv
// Directed self-checking bench for hash_display_unit (button toggle, hasher, BCD display).
module tb_hash_display_unit;
    import hash_display_pkg::*;

`ifdef HASH_DISP_REG_OUT_EN
    localparam int DIG_LAT = 1;
`else
    localparam int DIG_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        button_in;
    logic        hash_tick;
    logic [15:0] cur_time;
    logic [15:0] student_id;
    logic        stateful_button;
    logic [15:0] cur_hash;
    logic [3:0]  d5_out, d4_out, d3_out, d2_out, d1_out;
    btn_state_t  fsm_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] model_hash;

    wire [19:0] digits = {d5_out, d4_out, d3_out, d2_out, d1_out};

    hash_display_unit #(.SYNC_STAGES(2), .HASH_ROT(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .button_in       (button_in),
        .hash_tick       (hash_tick),
        .cur_time        (cur_time),
        .student_id      (student_id),
        .stateful_button (stateful_button),
        .cur_hash        (cur_hash),
        .d5_out          (d5_out),
        .d4_out          (d4_out),
        .d3_out          (d3_out),
        .d2_out          (d2_out),
        .d1_out          (d1_out),
        .fsm_state_o     (fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rotl(input logic [15:0] x, input int r);
        logic [15:0] v;
        v = x;
        for (int k = 0; k < r; k++) v = {v[14:0], v[15]};
        return v;
    endfunction

    function automatic logic [15:0] rotr(input logic [15:0] x, input int r);
        logic [15:0] v;
        v = x;
        for (int k = 0; k < r; k++) v = {v[0], v[15:1]};
        return v;
    endfunction

    function automatic logic [15:0] hash_ref(input logic [15:0] h, input logic [15:0] id,
                                             input logic [15:0] t);
        logic [15:0] s;
        s = (h ^ id) + t;
        return rotl(s, 3);
    endfunction

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic press_button();
        button_in = 1'b1;
        wait_cycles(6);
        button_in = 1'b0;
        wait_cycles(6);
    endtask

    task automatic tick_once(input logic [15:0] id, input logic [15:0] t);
        student_id = id;
        cur_time   = t;
        hash_tick  = 1'b1;
        model_hash = hash_ref(model_hash, id, t);
        @(negedge clk);
        hash_tick  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; button_in = 1'b0; hash_tick = 1'b0; cur_time = '0; student_id = '0;
        model_hash = '0;
        wait_cycles(2);
        rst = 1'b0;
        @(negedge clk);
        tick_once(16'h00FF, 16'h0101);
        n_tests++;
        if (cur_hash !== 16'h1000) begin
            n_fail++; $display("FAIL reset_pre_hash: got %h want %h", cur_hash, 16'h1000);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (cur_hash !== 16'h0000 || stateful_button !== 1'b0 || fsm_state !== OFF_REL) begin
            n_fail++;
            $display("FAIL reset_async: hash %h btn %b state %0d want 0000 0 0",
                     cur_hash, stateful_button, fsm_state);
        end
        n_tests++;
        if (digits !== 20'hFFFFF) begin
            n_fail++; $display("FAIL reset_digits: got %h want FFFFF", digits);
        end
        @(negedge clk);
        rst = 1'b0;
        model_hash = '0;
        @(negedge clk);
    endtask

    task automatic test_button();
        logic exp;
        button_in = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            exp = (c >= 3);
            n_tests++;
            if (stateful_button !== exp) begin
                n_fail++; $display("FAIL press1_cycle%0d: got %b want %b", c, stateful_button, exp);
            end
        end
        button_in = 1'b0;
        wait_cycles(6);
        n_tests++;
        if (stateful_button !== 1'b1 || fsm_state !== ON_REL) begin
            n_fail++; $display("FAIL release1: btn %b state %0d want 1 %0d",
                               stateful_button, fsm_state, ON_REL);
        end
        button_in = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp = (c < 3);
            n_tests++;
            if (stateful_button !== exp) begin
                n_fail++; $display("FAIL press2_cycle%0d: got %b want %b", c, stateful_button, exp);
            end
        end
        button_in = 1'b0;
        wait_cycles(6);
        n_tests++;
        if (stateful_button !== 1'b0 || fsm_state !== OFF_REL) begin
            n_fail++; $display("FAIL release2: btn %b state %0d want 0 0", stateful_button, fsm_state);
        end
    endtask

    task automatic test_single_tick();
        press_button();
        wait_cycles(DIG_LAT);
        n_tests++;
        if (digits !== 20'h00000) begin
            n_fail++; $display("FAIL bcd_zero: got %h want 00000", digits);
        end
        tick_once(16'h1234, 16'h0001);
        n_tests++;
        if (cur_hash !== 16'h91A8) begin
            n_fail++; $display("FAIL single_tick_hash: got %h want 91a8", cur_hash);
        end
`ifdef HASH_DISP_REG_OUT_EN
        n_tests++;
        if (digits !== 20'h00000) begin
            n_fail++; $display("FAIL reg_digit_lag: got %h want 00000", digits);
        end
`endif
        wait_cycles(DIG_LAT);
        n_tests++;
        if (digits !== 20'h37288) begin
            n_fail++; $display("FAIL single_tick_digits: got %h want 37288", digits);
        end
    endtask

    task automatic test_hold();
        for (int i = 1; i <= 100; i++) begin
            cur_time   = 16'(i * 97);
            student_id = 16'(i * 13);
            @(negedge clk);
            if (i % 25 == 0) begin
                n_tests++;
                if (cur_hash !== 16'h91A8) begin
                    n_fail++; $display("FAIL hold_cycle%0d: got %h want 91a8", i, cur_hash);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        student_id = 16'hBEEF;
        hash_tick  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cur_time   = 16'(16'h0101 * i + 3);
            model_hash = hash_ref(model_hash, student_id, cur_time);
            @(negedge clk);
            if (i == 0) begin
                n_tests++;
                if (cur_hash !== 16'h7A51) begin
                    n_fail++; $display("FAIL b2b_first: got %h want 7a51", cur_hash);
                end
            end
            n_tests++;
            if (cur_hash !== model_hash) begin
                n_fail++; $display("FAIL b2b_step%0d: got %h want %h", i, cur_hash, model_hash);
            end
        end
        hash_tick = 1'b0;
    endtask

    task automatic test_bcd_bounds();
        tick_once(16'h0000, rotr(16'd9999, 3) - model_hash);
        n_tests++;
        if (cur_hash !== 16'd9999) begin
            n_fail++; $display("FAIL force_9999: got %0d want 9999", cur_hash);
        end
        wait_cycles(DIG_LAT);
        n_tests++;
        if (digits !== 20'h09999) begin
            n_fail++; $display("FAIL bcd_9999: got %h want 09999", digits);
        end
        tick_once(16'h0000, rotr(16'hFFFF, 3) - model_hash);
        n_tests++;
        if (cur_hash !== 16'hFFFF) begin
            n_fail++; $display("FAIL force_65535: got %0d want 65535", cur_hash);
        end
        wait_cycles(DIG_LAT);
        n_tests++;
        if (digits !== 20'h65535) begin
            n_fail++; $display("FAIL bcd_65535: got %h want 65535", digits);
        end
        press_button();
        n_tests++;
        if (stateful_button !== 1'b0 || digits !== 20'hFFFFF) begin
            n_fail++; $display("FAIL blank_off: btn %b digits %h want 0 FFFFF", stateful_button, digits);
        end
        tick_once(16'h0000, 16'h0000 - model_hash);
        n_tests++;
        if (cur_hash !== 16'h0000 || digits !== 20'hFFFFF) begin
            n_fail++; $display("FAIL hash_while_off: hash %h digits %h want 0000 FFFFF", cur_hash, digits);
        end
    endtask

    task automatic test_reset_mid_press();
        tick_once(16'h0000, 16'h0005);
        n_tests++;
        if (cur_hash !== 16'h0028) begin
            n_fail++; $display("FAIL pre_reset_hash: got %h want 0028", cur_hash);
        end
        button_in = 1'b1;
        wait_cycles(5);
        n_tests++;
        if (stateful_button !== 1'b1) begin
            n_fail++; $display("FAIL mid_press_on: got %b want 1", stateful_button);
        end
        student_id = 16'h1111;
        cur_time   = 16'h2222;
        hash_tick  = 1'b1;
        rst        = 1'b1;
        @(negedge clk);
        n_tests++;
        if (cur_hash !== 16'h0000 || stateful_button !== 1'b0 || digits !== 20'hFFFFF) begin
            n_fail++; $display("FAIL reset_vs_tick: hash %h btn %b digits %h want 0000 0 FFFFF",
                               cur_hash, stateful_button, digits);
        end
        hash_tick = 1'b0;
        rst       = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (stateful_button !== (c >= 3)) begin
                n_fail++; $display("FAIL repress_cycle%0d: got %b want %b", c, stateful_button, c >= 3);
            end
        end
        button_in = 1'b0;
        wait_cycles(4);
    endtask

    initial begin
        test_reset();
        test_button();
        test_single_tick();
        test_hold();
        test_back_to_back();
        test_bcd_bounds();
        test_reset_mid_press();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_display_unit.md
Name: hash_display_unit

Overview:
- Single-clock block that keeps a 16-bit rolling hash of a student ID and the current time, and converts it to five BCD digits for a display.
- A toggle FSM driven by a push button gates the digit outputs on and off.
- Sits between the RTC divider/timekeeper, which supply hash_tick and cur_time, and the 7-segment digit drivers.

Parameters:
- SYNC_STAGES, 2: number of flops in the button_in synchronizer (minimum 2).
- HASH_ROT, 3: left-rotate amount applied in the hash update (range 0..15).

Ports:
- clk  in  1  system clock (1 MHz nominal).
- rst  in  1  asynchronous reset, active-high.
- button_in  in  1  raw push-button level; asynchronous to clk.
- hash_tick  in  1  one-cycle strobe; the hash updates on each cycle where it is 1.
- cur_time  in  16  current time count from the timekeeper.
- student_id  in  16  static student ID key.
- stateful_button  out  1  toggled button state; doubles as display enable.
- cur_hash  out  16  current hash register.
- d5_out, d4_out, d3_out, d2_out, d1_out  out  4 each  BCD digits; d5 = ten-thousands, d1 = units.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: sync flops 0; FSM state OFF_REL; stateful_button 0; cur_hash 0x0000; digits 4'hF (blank, since enable is 0).
- Button synchronizer:
  - SYNC_STAGES-flop chain; the synchronized level is btn_s.
  - Latency from button_in to FSM input is SYNC_STAGES cycles.
- Toggle FSM, 4 states, registered, transitions on btn_s:
  - OFF_REL(out 0): btn_s=1 -> ON_PRS.
  - ON_PRS(out 1): btn_s=0 -> ON_REL.
  - ON_REL(out 1): btn_s=1 -> OFF_PRS.
  - OFF_PRS(out 0): btn_s=0 -> OFF_REL.
  - Otherwise the FSM holds its state.
  - stateful_button is a Moore output.
  - Total press-to-output latency is SYNC_STAGES+1 cycles.
  - Holding the button produces exactly one toggle.
- Hasher:
  - On a clk edge with hash_tick=1: tmp = (cur_hash XOR student_id) + cur_time, mod 2^16; cur_hash <= tmp rotated left by HASH_ROT.
  - With hash_tick=0, cur_hash holds.
  - The new value is visible the cycle after the tick.
  - Back-to-back ticks update on every cycle.
  - The hash updates regardless of display enable.
- BCD conversion:
  - Combinational double-dabble of cur_hash (0..65535) into 5 digits, each 0..9.
  - Example: 65535 -> 6,5,5,3,5.
- Display gating:
  - enable = stateful_button.
  - Enable 1: digits show the BCD of cur_hash, same cycle as cur_hash changes.
  - Enable 0: all five digits = 4'hF (blank).
- Reset mid-press: FSM returns to OFF_REL immediately. If the button is still held when reset releases, the FSM enters ON_PRS once btn_s=1 after SYNC_STAGES cycles (treated as a new press).
- Reset coincident with hash_tick: reset wins; cur_hash = 0.

Optional Feature:
- Macro HASH_DISP_REG_OUT_EN.
- Defined: the five digit outputs are registered (reset to 4'hF). Digits lag cur_hash/enable by 1 cycle.
- Undefined: digits are purely combinational from cur_hash and stateful_button.

Decomposition:
- Package hash_display_pkg contains:
  - btn_state_t enum {OFF_REL, ON_PRS, ON_REL, OFF_PRS};
  - BCD_BLANK = 4'hF;
  - HASH_W = 16;
  - NUM_DIGITS = 5.
- One sub-module, bin16_to_bcd5: combinational 16-bit to 5×4-bit double-dabble converter.
- FSM and hasher stay inline in hash_display_unit.

Test Plan:
- Reset: assert rst mid-cycle -> immediately cur_hash=0, stateful_button=0, all digits 4'hF.
- Button press: button_in 0->1 held 10 cycles, then 0 -> stateful_button rises SYNC_STAGES+1=3 cycles after the press and stays 1. A second press drops it to 0. Glitch-free single toggle per press.
- Single hash tick: cur_hash=0, student_id=0x1234, cur_time=1, one-cycle hash_tick -> next cycle cur_hash=0x91A8 (37288); with enable=1 digits 3,7,2,8,8.
- Hold and back-to-back ticks: hash_tick low for 100 cycles -> cur_hash unchanged. Consecutive-cycle ticks -> one update per cycle, matching a reference model.
- BCD boundaries with enable=1: force via ticks/model cur_hash 0 -> 0,0,0,0,0; 9999 -> 0,9,9,9,9; 65535 -> 6,5,5,3,5. With enable=0 -> all 4'hF.
- Macro build with HASH_DISP_REG_OUT_EN: same tick stimulus -> digits change one cycle after cur_hash. Reset blanks the registered digits asynchronously.
